// File: rtl/lsu_rd_pack_if.sv
`default_nettype none
// ============================================================================
// Module   : lsu_rd_pack_if
// Brief    : Command, AXI R-channel, RAM row-write and done signals of the
//            LSU read-response packer.
// Revision : 1.0 - initial release
// ============================================================================
interface lsu_rd_pack_if #(
    parameter int ADDR_W = 12,
    parameter int ID_W   = 8
);
    logic              cmd_vld;
    logic              cmd_rdy;
    logic [ID_W-1:0]   cmd_id;
    logic [7:0]        cmd_len;
    logic              cmd_dst;
    logic [ADDR_W-1:0] cmd_addr;

    logic [ID_W-1:0]   axi_lsu_rid;
    logic [63:0]       axi_lsu_rdata;
    logic [1:0]        axi_lsu_rresp;
    logic              axi_lsu_rlast;
    logic              axi_lsu_rvld;
    logic              lsu_axi_rrdy;

    logic              ram_wr_vld;
    logic              ram_wr_rdy;
    logic              ram_wr_sel;
    logic [ADDR_W-1:0] ram_wr_addr;
    logic [127:0]      ram_wr_data;
    logic [1:0]        ram_wr_mask;

    logic              done_vld;
    logic              done_err;

    // master: the packer itself; slave: the LSU / AXI / RAM surroundings
    modport master (
        input  cmd_vld, cmd_id, cmd_len, cmd_dst, cmd_addr,
        input  axi_lsu_rid, axi_lsu_rdata, axi_lsu_rresp, axi_lsu_rlast, axi_lsu_rvld,
        input  ram_wr_rdy,
        output cmd_rdy, lsu_axi_rrdy,
        output ram_wr_vld, ram_wr_sel, ram_wr_addr, ram_wr_data, ram_wr_mask,
        output done_vld, done_err
    );

    modport slave (
        output cmd_vld, cmd_id, cmd_len, cmd_dst, cmd_addr,
        output axi_lsu_rid, axi_lsu_rdata, axi_lsu_rresp, axi_lsu_rlast, axi_lsu_rvld,
        output ram_wr_rdy,
        input  cmd_rdy, lsu_axi_rrdy,
        input  ram_wr_vld, ram_wr_sel, ram_wr_addr, ram_wr_data, ram_wr_mask,
        input  done_vld, done_err
    );
endinterface
`default_nettype wire

// File: rtl/lsu_rd_pack.sv
`default_nettype none
// ============================================================================
// Module   : lsu_rd_pack
// Brief    : Packs 64-bit AXI R beats pairwise into 128-bit IRAM/WRAM rows
//            with auto-incrementing row address; one done/error pulse per burst.
//            Optional stall counter port enabled by LSU_RD_PACK_PERF_EN.
// Revision : 1.0 - initial release
// ============================================================================
module lsu_rd_pack #(
    parameter int ADDR_W = 12,
    parameter int ID_W   = 8
) (
    input  wire              clk,
    input  wire              rst,
    lsu_rd_pack_if.master    bus
`ifdef LSU_RD_PACK_PERF_EN
    ,
    output logic [15:0]      perf_stall_cnt
`endif
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LO   = 3'd1,
        S_HI   = 3'd2,
        S_WR   = 3'd3,
        S_DONE = 3'd4
    } state_t;

    localparam logic [ADDR_W-1:0] c_addr_one = ADDR_W'(1);

    state_t            r_state;
    logic              r_cmd_rdy;
    logic              r_rrdy;
    logic              r_wr_vld;
    logic              r_done_vld;
    logic              r_done_err;
    logic [ID_W-1:0]   r_id;
    logic [7:0]        r_len;
    logic              r_sel;
    logic [ADDR_W-1:0] r_addr;
    logic [127:0]      r_row;
    logic [1:0]        r_mask;
    logic [8:0]        r_beat_cnt;
    logic              r_err;
    logic              r_fin;

    logic w_cmd_fire;
    logic w_beat_fire;
    logic w_wr_fire;
    logic w_expect_last;
    logic w_final;
    logic w_beat_err;

    assign w_cmd_fire    = bus.cmd_vld & r_cmd_rdy;
    assign w_beat_fire   = bus.axi_lsu_rvld & r_rrdy;
    assign w_wr_fire     = r_wr_vld & bus.ram_wr_rdy;
    assign w_expect_last = (r_beat_cnt == {1'b0, r_len});
    assign w_final       = w_expect_last | bus.axi_lsu_rlast;
    // rlast disagreeing with the beat count in either direction is a protocol error
    assign w_beat_err    = (bus.axi_lsu_rresp != 2'b00)
                         | (bus.axi_lsu_rid != r_id)
                         | (bus.axi_lsu_rlast ^ w_expect_last);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_cmd_rdy  <= 1'b1;
            r_rrdy     <= 1'b0;
            r_wr_vld   <= 1'b0;
            r_done_vld <= 1'b0;
            r_done_err <= 1'b0;
            r_id       <= '0;
            r_len      <= '0;
            r_sel      <= 1'b0;
            r_addr     <= '0;
            r_row      <= '0;
            r_mask     <= 2'b00;
            r_beat_cnt <= '0;
            r_err      <= 1'b0;
            r_fin      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_cmd_fire) begin
                        r_id       <= bus.cmd_id;
                        r_len      <= bus.cmd_len;
                        r_sel      <= bus.cmd_dst;
                        r_addr     <= bus.cmd_addr;
                        r_beat_cnt <= '0;
                        r_err      <= 1'b0;
                        r_fin      <= 1'b0;
                        r_cmd_rdy  <= 1'b0;
                        r_rrdy     <= 1'b1;
                        r_state    <= S_LO;
                    end
                end
                S_LO: begin
                    if (w_beat_fire) begin
                        // upper half cleared so an odd final row carries zeros
                        r_row      <= {64'd0, bus.axi_lsu_rdata};
                        r_beat_cnt <= r_beat_cnt + 9'd1;
                        r_err      <= r_err | w_beat_err;
                        if (w_final) begin
                            r_mask   <= 2'b01;
                            r_fin    <= 1'b1;
                            r_rrdy   <= 1'b0;
                            r_wr_vld <= 1'b1;
                            r_state  <= S_WR;
                        end else begin
                            r_state  <= S_HI;
                        end
                    end
                end
                S_HI: begin
                    if (w_beat_fire) begin
                        r_row[127:64] <= bus.axi_lsu_rdata;
                        r_beat_cnt    <= r_beat_cnt + 9'd1;
                        r_err         <= r_err | w_beat_err;
                        r_mask        <= 2'b11;
                        r_fin         <= w_final;
                        r_rrdy        <= 1'b0;
                        r_wr_vld      <= 1'b1;
                        r_state       <= S_WR;
                    end
                end
                S_WR: begin
                    if (w_wr_fire) begin
                        r_addr   <= r_addr + c_addr_one;
                        r_wr_vld <= 1'b0;
                        if (r_fin) begin
                            r_done_vld <= 1'b1;
                            r_done_err <= r_err;
                            r_state    <= S_DONE;
                        end else begin
                            r_rrdy     <= 1'b1;
                            r_state    <= S_LO;
                        end
                    end
                end
                S_DONE: begin
                    r_done_vld <= 1'b0;
                    r_done_err <= 1'b0;
                    r_cmd_rdy  <= 1'b1;
                    r_state    <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

`ifdef LSU_RD_PACK_PERF_EN
    localparam logic [15:0] c_stall_max = 16'hFFFF;

    logic [15:0] r_stall_cnt;

    always_ff @(posedge clk) begin
        if (rst || w_cmd_fire) begin
            r_stall_cnt <= '0;
        end else if (r_state == S_WR && !bus.ram_wr_rdy && r_stall_cnt != c_stall_max) begin
            r_stall_cnt <= r_stall_cnt + 16'd1;
        end
    end

    assign perf_stall_cnt = r_stall_cnt;
`endif

    assign bus.cmd_rdy      = r_cmd_rdy;
    assign bus.lsu_axi_rrdy = r_rrdy;
    assign bus.ram_wr_vld   = r_wr_vld;
    assign bus.ram_wr_sel   = r_sel;
    assign bus.ram_wr_addr  = r_addr;
    assign bus.ram_wr_data  = r_row;
    assign bus.ram_wr_mask  = r_mask;
    assign bus.done_vld     = r_done_vld;
    assign bus.done_err     = r_done_err;

endmodule
`default_nettype wire

// File: tb/tb_lsu_rd_pack.sv
`default_nettype none
// ============================================================================
// Module   : tb_lsu_rd_pack
// Brief    : Directed self-checking bench for lsu_rd_pack (build with
//            LSU_RD_PACK_PERF_EN defined to also cover perf_stall_cnt).
// Revision : 1.0 - initial release
// ============================================================================
module tb_lsu_rd_pack;
    localparam int ADDR_W = 12;
    localparam int ID_W   = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    lsu_rd_pack_if #(.ADDR_W(ADDR_W), .ID_W(ID_W)) bus ();
`ifdef LSU_RD_PACK_PERF_EN
    logic [15:0] perf_stall_cnt;
`endif

    lsu_rd_pack #(.ADDR_W(ADDR_W), .ID_W(ID_W)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
`ifdef LSU_RD_PACK_PERF_EN
        ,
        .perf_stall_cnt(perf_stall_cnt)
`endif
    );

    int checks = 0;
    int passed = 0;

    logic [63:0]       b_data [8];
    logic              b_last [8];
    logic [1:0]        b_resp [8];
    logic [ID_W-1:0]   b_id   [8];
    int                nb;

    logic [ADDR_W-1:0] w_addr [8];
    logic [127:0]      w_data [8];
    logic [1:0]        w_mask [8];
    logic              w_sel  [8];
    int                nw;
    logic              d_err;
    bit                got_done;
    int                stall_seen;
    int                stable_bad;

    task automatic set_beat(input int i, input logic [63:0] d, input logic last,
                            input logic [1:0] resp, input logic [ID_W-1:0] id);
        b_data[i] = d; b_last[i] = last; b_resp[i] = resp; b_id[i] = id;
    endtask

    task automatic present(input int i);
        bus.axi_lsu_rvld = (i < nb);
        if (i < nb) begin
            bus.axi_lsu_rdata = b_data[i]; bus.axi_lsu_rlast = b_last[i];
            bus.axi_lsu_rresp = b_resp[i]; bus.axi_lsu_rid   = b_id[i];
        end else begin
            bus.axi_lsu_rdata = '0; bus.axi_lsu_rlast = 1'b0;
            bus.axi_lsu_rresp = '0; bus.axi_lsu_rid   = '0;
        end
    endtask

    // Issues one command and plays the AXI/RAM sides until done_vld; returns
    // one cycle after done_vld, 1 time unit past the rising edge.
    task automatic run_burst(input logic [7:0] len, input logic dst,
                             input logic [ADDR_W-1:0] addr, input logic [ID_W-1:0] id,
                             input int stall);
        int bi; int stall_left; bit fire;
        logic [127:0] s_data; logic [ADDR_W-1:0] s_addr;
        bi = 0; nw = 0; got_done = 0; stall_seen = 0; stable_bad = 0; d_err = 1'bx;
        stall_left = stall; s_data = '0; s_addr = '0;
        bus.cmd_vld = 1'b1; bus.cmd_len = len; bus.cmd_dst = dst;
        bus.cmd_addr = addr; bus.cmd_id = id;
        present(0);
        bus.ram_wr_rdy = (stall == 0);
        for (int cyc = 0; cyc < 200 && !got_done; cyc++) begin
            @(negedge clk);
            fire = bus.axi_lsu_rvld && bus.lsu_axi_rrdy;
            if (bus.ram_wr_vld) begin
                if (bus.ram_wr_rdy) begin
                    if (nw < 8) begin
                        w_addr[nw] = bus.ram_wr_addr; w_data[nw] = bus.ram_wr_data;
                        w_mask[nw] = bus.ram_wr_mask; w_sel[nw]  = bus.ram_wr_sel;
                    end
                    nw++;
                end else begin
                    if (stall_seen == 0) begin
                        s_data = bus.ram_wr_data; s_addr = bus.ram_wr_addr;
                    end else if (bus.ram_wr_data !== s_data || bus.ram_wr_addr !== s_addr) begin
                        stable_bad++;
                    end
                    if (bus.lsu_axi_rrdy !== 1'b0) stable_bad++;
                    stall_seen++;
                    if (stall_left > 0) stall_left--;
                end
            end
            if (bus.done_vld) begin got_done = 1; d_err = bus.done_err; end
            @(posedge clk); #1;
            bus.cmd_vld = 1'b0;
            if (fire) bi++;
            present(bi);
            bus.ram_wr_rdy = (stall_left == 0);
        end
        checks++; if (!got_done) $display("FAIL done_timeout: got no done_vld, want done_vld"); else passed++;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        checks++; if (bus.cmd_rdy !== 1'b1) $display("FAIL rst_cmd_rdy: got %b want 1", bus.cmd_rdy); else passed++;
        checks++; if (bus.lsu_axi_rrdy !== 1'b0) $display("FAIL rst_rrdy: got %b want 0", bus.lsu_axi_rrdy); else passed++;
        checks++; if (bus.ram_wr_vld !== 1'b0) $display("FAIL rst_wr_vld: got %b want 0", bus.ram_wr_vld); else passed++;
        checks++; if (bus.done_vld !== 1'b0) $display("FAIL rst_done_vld: got %b want 0", bus.done_vld); else passed++;
        checks++; if (bus.ram_wr_mask !== 2'b00 || bus.ram_wr_data !== 128'd0 || bus.ram_wr_addr !== 12'h000)
            $display("FAIL rst_wr_bus: got mask %b data %h addr %h want zeros", bus.ram_wr_mask, bus.ram_wr_data, bus.ram_wr_addr);
        else passed++;
    endtask

    task automatic test_basic();
        nb = 4;
        set_beat(0, 64'h1111_1111_1111_1111, 1'b0, 2'b00, 8'h21);
        set_beat(1, 64'h2222_2222_2222_2222, 1'b0, 2'b00, 8'h21);
        set_beat(2, 64'h3333_3333_3333_3333, 1'b0, 2'b00, 8'h21);
        set_beat(3, 64'h4444_4444_4444_4444, 1'b1, 2'b00, 8'h21);
        run_burst(8'd3, 1'b0, 12'h010, 8'h21, 0);
        checks++; if (nw !== 2) $display("FAIL basic_nwr: got %0d want 2", nw); else passed++;
        checks++; if (w_addr[0] !== 12'h010 || w_mask[0] !== 2'b11 || w_sel[0] !== 1'b0)
            $display("FAIL basic_row0_ctl: got addr %h mask %b sel %b want 010 11 0", w_addr[0], w_mask[0], w_sel[0]); else passed++;
        checks++; if (w_data[0] !== {64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111})
            $display("FAIL basic_row0_data: got %h want 2222..1111..", w_data[0]); else passed++;
        checks++; if (w_addr[1] !== 12'h011 || w_mask[1] !== 2'b11)
            $display("FAIL basic_row1_ctl: got addr %h mask %b want 011 11", w_addr[1], w_mask[1]); else passed++;
        checks++; if (w_data[1] !== {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333})
            $display("FAIL basic_row1_data: got %h want 4444..3333..", w_data[1]); else passed++;
        checks++; if (d_err !== 1'b0) $display("FAIL basic_err: got %b want 0", d_err); else passed++;
        checks++; if (bus.cmd_rdy !== 1'b1 || bus.done_vld !== 1'b0)
            $display("FAIL basic_after: got cmd_rdy %b done_vld %b want 1 0", bus.cmd_rdy, bus.done_vld); else passed++;
    endtask

    task automatic test_wrap();
        nb = 3;
        set_beat(0, 64'hAAAA_AAAA_AAAA_AAAA, 1'b0, 2'b00, 8'h07);
        set_beat(1, 64'hBBBB_BBBB_BBBB_BBBB, 1'b0, 2'b00, 8'h07);
        set_beat(2, 64'hCCCC_CCCC_CCCC_CCCC, 1'b1, 2'b00, 8'h07);
        run_burst(8'd2, 1'b1, 12'hFFF, 8'h07, 0);
        checks++; if (nw !== 2) $display("FAIL wrap_nwr: got %0d want 2", nw); else passed++;
        checks++; if (w_addr[0] !== 12'hFFF || w_mask[0] !== 2'b11 || w_data[0] !== {64'hBBBB_BBBB_BBBB_BBBB, 64'hAAAA_AAAA_AAAA_AAAA})
            $display("FAIL wrap_row0: got addr %h mask %b data %h", w_addr[0], w_mask[0], w_data[0]); else passed++;
        checks++; if (w_addr[1] !== 12'h000 || w_mask[1] !== 2'b01 || w_data[1] !== {64'd0, 64'hCCCC_CCCC_CCCC_CCCC})
            $display("FAIL wrap_row1: got addr %h mask %b data %h want 000 01 0..CCCC..", w_addr[1], w_mask[1], w_data[1]); else passed++;
        checks++; if (w_sel[0] !== 1'b1 || w_sel[1] !== 1'b1)
            $display("FAIL wrap_sel: got %b %b want 1 1", w_sel[0], w_sel[1]); else passed++;
        checks++; if (d_err !== 1'b0) $display("FAIL wrap_err: got %b want 0", d_err); else passed++;
    endtask

    task automatic test_len0();
        nb = 1;
        set_beat(0, 64'h5555_6666_7777_8888, 1'b1, 2'b00, 8'h01);
        run_burst(8'd0, 1'b0, 12'h007, 8'h01, 0);
        checks++; if (nw !== 1 || w_addr[0] !== 12'h007 || w_mask[0] !== 2'b01 || w_data[0] !== {64'd0, 64'h5555_6666_7777_8888})
            $display("FAIL len0_row: got n %0d addr %h mask %b data %h", nw, w_addr[0], w_mask[0], w_data[0]); else passed++;
        checks++; if (d_err !== 1'b0) $display("FAIL len0_err: got %b want 0", d_err); else passed++;
    endtask

    task automatic test_stall();
        nb = 4;
        set_beat(0, 64'h0A0A_0A0A_0A0A_0A0A, 1'b0, 2'b00, 8'h44);
        set_beat(1, 64'h0B0B_0B0B_0B0B_0B0B, 1'b0, 2'b00, 8'h44);
        set_beat(2, 64'h0C0C_0C0C_0C0C_0C0C, 1'b0, 2'b00, 8'h44);
        set_beat(3, 64'h0D0D_0D0D_0D0D_0D0D, 1'b1, 2'b00, 8'h44);
        run_burst(8'd3, 1'b0, 12'h100, 8'h44, 5);
        checks++; if (stall_seen !== 5) $display("FAIL stall_cycles: got %0d want 5", stall_seen); else passed++;
        checks++; if (stable_bad !== 0) $display("FAIL stall_stable: got %0d violations want 0", stable_bad); else passed++;
        checks++; if (nw !== 2 || w_addr[0] !== 12'h100 || w_addr[1] !== 12'h101)
            $display("FAIL stall_addr: got n %0d addr %h %h want 2 100 101", nw, w_addr[0], w_addr[1]); else passed++;
        checks++; if (w_data[0] !== {64'h0B0B_0B0B_0B0B_0B0B, 64'h0A0A_0A0A_0A0A_0A0A} ||
                      w_data[1] !== {64'h0D0D_0D0D_0D0D_0D0D, 64'h0C0C_0C0C_0C0C_0C0C})
            $display("FAIL stall_data: got %h %h", w_data[0], w_data[1]); else passed++;
`ifdef LSU_RD_PACK_PERF_EN
        checks++; if (perf_stall_cnt !== 16'd5) $display("FAIL stall_perf: got %0d want 5", perf_stall_cnt); else passed++;
`endif
    endtask

    task automatic test_early_last();
        nb = 2;
        set_beat(0, 64'h1234_0000_0000_0001, 1'b0, 2'b00, 8'h09);
        set_beat(1, 64'h1234_0000_0000_0002, 1'b1, 2'b00, 8'h09);
        run_burst(8'd3, 1'b0, 12'h040, 8'h09, 0);
        checks++; if (nw !== 1 || w_mask[0] !== 2'b11 || w_data[0] !== {64'h1234_0000_0000_0002, 64'h1234_0000_0000_0001})
            $display("FAIL early_row: got n %0d mask %b data %h", nw, w_mask[0], w_data[0]); else passed++;
        checks++; if (d_err !== 1'b1) $display("FAIL early_err: got %b want 1", d_err); else passed++;
        checks++; if (bus.cmd_rdy !== 1'b1 || bus.lsu_axi_rrdy !== 1'b0)
            $display("FAIL early_idle: got cmd_rdy %b rrdy %b want 1 0", bus.cmd_rdy, bus.lsu_axi_rrdy); else passed++;
    endtask

    task automatic test_resp_err();
        nb = 2;
        set_beat(0, 64'h0123_4567_89AB_CDEF, 1'b0, 2'b00, 8'h5A);
        set_beat(1, 64'hFEDC_BA98_7654_3210, 1'b1, 2'b10, 8'h33);
        run_burst(8'd1, 1'b1, 12'h200, 8'h5A, 0);
        checks++; if (nw !== 1 || w_mask[0] !== 2'b11 || w_data[0] !== {64'hFEDC_BA98_7654_3210, 64'h0123_4567_89AB_CDEF})
            $display("FAIL resp_row: got n %0d mask %b data %h", nw, w_mask[0], w_data[0]); else passed++;
        checks++; if (d_err !== 1'b1) $display("FAIL resp_err: got %b want 1", d_err); else passed++;
        set_beat(1, 64'hFEDC_BA98_7654_3210, 1'b1, 2'b00, 8'h5A);
        run_burst(8'd1, 1'b1, 12'h201, 8'h5A, 0);
        checks++; if (d_err !== 1'b0) $display("FAIL resp_clean_err: got %b want 0", d_err); else passed++;
    endtask

    task automatic test_reset_mid();
        nb = 4;
        set_beat(0, 64'h9999_0000_0000_0001, 1'b0, 2'b00, 8'h11);
        bus.cmd_vld = 1'b1; bus.cmd_len = 8'd3; bus.cmd_dst = 1'b1;
        bus.cmd_addr = 12'h300; bus.cmd_id = 8'h11; bus.ram_wr_rdy = 1'b1;
        present(0);
        @(posedge clk); #1;
        bus.cmd_vld = 1'b0;
        @(posedge clk); #1;
        checks++; if (bus.lsu_axi_rrdy !== 1'b1 || bus.ram_wr_vld !== 1'b0)
            $display("FAIL mid_in_hi: got rrdy %b wr_vld %b want 1 0", bus.lsu_axi_rrdy, bus.ram_wr_vld); else passed++;
        rst = 1'b1; nb = 0; present(0);
        @(posedge clk); #1;
        rst = 1'b0;
        checks++; if (bus.cmd_rdy !== 1'b1 || bus.lsu_axi_rrdy !== 1'b0 || bus.ram_wr_vld !== 1'b0 || bus.done_vld !== 1'b0 ||
                      bus.done_err !== 1'b0 || bus.ram_wr_sel !== 1'b0 || bus.ram_wr_mask !== 2'b00 ||
                      bus.ram_wr_data !== 128'd0 || bus.ram_wr_addr !== 12'h000)
            $display("FAIL mid_reset_vals: got cmd_rdy %b rrdy %b wr_vld %b done %b sel %b mask %b addr %h",
                     bus.cmd_rdy, bus.lsu_axi_rrdy, bus.ram_wr_vld, bus.done_vld, bus.ram_wr_sel, bus.ram_wr_mask, bus.ram_wr_addr);
        else passed++;
        nb = 2;
        set_beat(0, 64'h7777_0000_0000_0001, 1'b0, 2'b00, 8'h12);
        set_beat(1, 64'h7777_0000_0000_0002, 1'b1, 2'b00, 8'h12);
        run_burst(8'd1, 1'b0, 12'h020, 8'h12, 0);
        checks++; if (nw !== 1 || w_addr[0] !== 12'h020 || w_mask[0] !== 2'b11 ||
                      w_data[0] !== {64'h7777_0000_0000_0002, 64'h7777_0000_0000_0001} || d_err !== 1'b0)
            $display("FAIL mid_recover: got n %0d addr %h mask %b data %h err %b", nw, w_addr[0], w_mask[0], w_data[0], d_err);
        else passed++;
    endtask

    initial begin
        rst = 1'b1;
        bus.cmd_vld = 1'b0; bus.cmd_id = '0; bus.cmd_len = '0; bus.cmd_dst = 1'b0; bus.cmd_addr = '0;
        bus.ram_wr_rdy = 1'b0;
        nb = 0; present(0);
        test_reset();
        test_basic();
        test_wrap();
        test_len0();
        test_stall();
        test_early_last();
        test_resp_err();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
`default_nettype wire
